// File: rtl/lab2_sub_sequencer.sv
// lab2_sub_sequencer: wide X - Y - Bin computed one nibble per clock
// on a shared 4-bit borrow-lookahead slice, LSB nibble first.
module lab2_sub_sequencer #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] X,
  input  logic [4*NIB-1:0] Y,
  input  logic             Bin,
  output logic [4*NIB-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int W  = 4 * NIB;
  localparam int KW = $clog2(NIB);
  localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  xr;
  logic [W-1:0]  yr;
  logic          br;
  logic [KW-1:0] k;

  logic [3:0] xn;
  logic [3:0] yn;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] bc;
  logic [3:0] dn;

  // Borrow-lookahead slice on the nibble selected by k.
  always_comb begin
    xn = xr[4*k +: 4];
    yn = yr[4*k +: 4];
    g  = ~xn & yn;
    p  = ~(xn ^ yn);
    bc[0] = br;
    bc[1] = g[0] | (p[0] & br);
    bc[2] = g[1] | (p[1] & g[0])
          | (p[1] & p[0] & br);
    bc[3] = g[2] | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & br);
    bc[4] = g[3] | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br);
    dn = xn ^ yn ^ bc[3:0];
  end

  // Sequencer: accept, step one nibble per edge, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      br    <= 1'b0;
      k     <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xr    <= X;
            yr    <= Y;
            br    <= Bin;
            k     <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          D[4*k +: 4] <= dn;
          br          <= bc[4];
          if (k == KLAST) begin
            Bout  <= bc[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
